// File: rtl/seg_arb_pkg.sv
// Shared types and widths for the seven-segment source arbiter.
package seg_arb_pkg;

  localparam int SEG_DATA_W  = 20;
  localparam int SEG_POINT_W = 6;
  localparam int OWNER_W     = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BLANK = 2'd2
  } arb_state_t;

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin finder: first requester after `last`, wrapping,
// skipping any source flagged in `excl`.
module seg_rr_pick
  import seg_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [OWNER_W-1:0] last,
  input  logic [NUM_REQ-1:0] excl,
  output logic               found,
  output logic [OWNER_W-1:0] idx
);

  logic [NUM_REQ-1:0] cand;
  int pos;

  always_comb begin
    cand  = req & ~excl;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    // Offset 1 first, so the previous winner is considered last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = (int'(last) + k) % NUM_REQ;
      if (!found && cand[pos]) begin
        found = 1'b1;
        idx   = OWNER_W'(pos);
      end
    end
  end

endmodule

// File: rtl/seg_src_arbiter.sv
// Round-robin owner of the six-digit display path with minimum dwell time.
// Define SEG_ARB_BLANK_EN to insert a blanking interval on every handover.
module seg_src_arbiter
  import seg_arb_pkg::*;
#(
  parameter int          NUM_REQ   = 3,
  parameter logic [23:0] DWELL_MAX = 24'd9_999_999,
  parameter logic [19:0] BLANK_MAX = 20'd249_999
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*SEG_DATA_W-1:0]  data_in,
  input  logic [NUM_REQ*SEG_POINT_W-1:0] point_in,
  input  logic [NUM_REQ-1:0]             sign_in,
  output logic [NUM_REQ-1:0]             grant,
  output logic [OWNER_W-1:0]             owner,
  output logic [SEG_DATA_W-1:0]          data,
  output logic [SEG_POINT_W-1:0]         point,
  output logic                           sign,
  output logic                           seg_en
);

  if (NUM_REQ < 2 || NUM_REQ > 4 || {4'd0, BLANK_MAX} >= DWELL_MAX) begin : g_bad_cfg
    $error("seg_src_arbiter: NUM_REQ must be 2..4 and BLANK_MAX below DWELL_MAX");
  end

  arb_state_t         state;
  logic [OWNER_W-1:0] last;
  logic [23:0]        dwell;
  logic [NUM_REQ-1:0] excl;
  logic               found;
  logic [OWNER_W-1:0] pick_idx;
  logic               dwell_sat;
  logic               do_grant;
  logic               do_idle;
`ifdef SEG_ARB_BLANK_EN
  logic               do_blank;
  logic [19:0]        blank_cnt;
`endif

  assign dwell_sat = (dwell == DWELL_MAX);
  // While holding, the owner is masked so a handover always finds a competitor.
  assign excl = (state == HOLD) ? (NUM_REQ'(1) << owner) : '0;

  seg_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req   (req),
    .last  (last),
    .excl  (excl),
    .found (found),
    .idx   (pick_idx)
  );

  always_comb begin
    do_grant = 1'b0;
    do_idle  = 1'b0;
`ifdef SEG_ARB_BLANK_EN
    do_blank = 1'b0;
`endif
    case (state)
      IDLE: do_grant = found;
      HOLD: begin
        if (!req[owner] || (dwell_sat && found)) begin
          if (!found) do_idle = 1'b1;
`ifdef SEG_ARB_BLANK_EN
          else        do_blank = 1'b1;
`else
          else        do_grant = 1'b1;
`endif
        end
      end
`ifdef SEG_ARB_BLANK_EN
      BLANK: begin
        if (blank_cnt == BLANK_MAX) begin
          do_grant = found;
          do_idle  = !found;
        end
      end
`endif
      default: do_idle = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= IDLE;
      last   <= OWNER_W'(NUM_REQ - 1);
      dwell  <= '0;
      grant  <= '0;
      owner  <= '0;
      data   <= '0;
      point  <= '0;
      sign   <= 1'b0;
      seg_en <= 1'b0;
`ifdef SEG_ARB_BLANK_EN
      blank_cnt <= '0;
`endif
    end else if (do_grant) begin
      state  <= HOLD;
      grant  <= NUM_REQ'(1) << pick_idx;
      owner  <= pick_idx;
      last   <= pick_idx;
      dwell  <= '0;
      seg_en <= 1'b1;
      data   <= data_in[int'(pick_idx)*SEG_DATA_W +: SEG_DATA_W];
      point  <= point_in[int'(pick_idx)*SEG_POINT_W +: SEG_POINT_W];
      sign   <= sign_in[pick_idx];
    end else if (do_idle) begin
      state  <= IDLE;
      grant  <= '0;
      seg_en <= 1'b0;
    end
`ifdef SEG_ARB_BLANK_EN
    else if (do_blank) begin
      state     <= BLANK;
      grant     <= '0;
      seg_en    <= 1'b0;
      blank_cnt <= '0;
    end else if (state == BLANK) begin
      blank_cnt <= blank_cnt + 1'b1;
    end
`endif
    else if (state == HOLD) begin
      if (!dwell_sat) dwell <= dwell + 1'b1;
      data  <= data_in[int'(owner)*SEG_DATA_W +: SEG_DATA_W];
      point <= point_in[int'(owner)*SEG_POINT_W +: SEG_POINT_W];
      sign  <= sign_in[owner];
    end
  end

endmodule
